// File: rtl/resolve.sv
// resolve: multi-cycle signed quadratic evaluator, y = a*x^2 + b*x + c.
// Horner form ((a*x) + b)*x + c on one shared multiplier, one shared adder
// and a single accumulator, sequenced by a six-state FSM.
// All arithmetic is 16-bit two's complement and wraps; no saturation.
module resolve (
  input  logic        inicio,
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  x,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  output logic [15:0] y,
  output logic        ready,
  output logic        valid
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    ADD1 = 3'd2,
    MUL2 = 3'd3,
    ADD2 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [15:0] xr, ar, br, cr, acc, yr;

  // Shared datapath: the multiplier takes AR in MUL1 and ACC in MUL2;
  // the adder adds BR in ADD1 and CR in ADD2. Only the low 16 bits of
  // the signed 32-bit product are kept.
  logic        [15:0] mul_op;
  logic        [15:0] add_op;
  logic signed [31:0] prod;
  logic        [15:0] sum;

  assign mul_op = (state == MUL1) ? ar : acc;
  assign add_op = (state == ADD1) ? br : cr;
  assign prod   = $signed(mul_op) * $signed(xr);
  assign sum    = acc + add_op;
  assign y      = yr;

  // State register; reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore outputs; start is honoured only in IDLE.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (inicio) state_nxt = MUL1;
      end
      MUL1: state_nxt = ADD1;
      ADD1: state_nxt = MUL2;
      MUL2: state_nxt = ADD2;
      ADD2: state_nxt = DONE;
      DONE: begin
        valid     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, accumulator steps and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      xr  <= '0;
      ar  <= '0;
      br  <= '0;
      cr  <= '0;
      acc <= '0;
      yr  <= '0;
    end else begin
      case (state)
        IDLE: if (inicio) begin
          xr <= {{8{x[7]}}, x};
          ar <= a;
          br <= b;
          cr <= c;
        end
        MUL1:    acc <= prod[15:0];
        ADD1:    acc <= sum;
        MUL2:    acc <= prod[15:0];
        ADD2:    yr  <= sum;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resolve.sv
// tb_resolve: directed vector table for resolve plus hand-written
// sequences for back-to-back starts, busy-time input changes and resets.
module tb_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic [7:0]  x;
  logic [15:0] a, b, c;
  logic [15:0] y;
  logic        ready, valid;

  int nvec = 0;
  int nerr = 0;

  resolve dut (
    .inicio(inicio),
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .a     (a),
    .b     (b),
    .c     (c),
    .y     (y),
    .ready (ready),
    .valid (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [15:0] a, b, c;
    logic [15:0] y;
    bit          disturb;
    string       name;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // One evaluation from IDLE: start, count cycles to valid, check result,
  // then confirm the pulse is single and the block is back in IDLE.
  task automatic run_eval(input vec_t v);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    x = v.x; a = v.a; b = v.b; c = v.c;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (valid) begin
        lat = k;
        break;
      end
      if (ready) busy_ok = 1'b0;
      if (v.disturb) begin
        x = ~x;
        a = a + 16'h1111;
        b = b - 16'h0123;
        c = c ^ 16'h5A5A;
        inicio = (k == 2);
      end
      @(negedge clk);
    end
    inicio = 1'b0;
    chk({v.name, " latency"}, lat, 5);
    chk({v.name, " y"}, y, v.y);
    chk({v.name, " ready low while busy"}, {busy_ok, ready}, 2'b10);
    @(negedge clk);
    chk({v.name, " single valid pulse"}, {valid, ready}, 2'b01);
    if (v.disturb) begin
      @(negedge clk);
      chk({v.name, " no restart from busy inicio"}, {valid, ready}, 2'b01);
    end
  endtask

  initial begin
    logic [17:0] vseen, rseen, vexp, rexp;
    bit yok;
    int nv;

    tv[0] = '{8'd1,   16'd2,     16'd3,      16'd4,      16'd9,      1'b0, "basic"};
    tv[1] = '{8'hFE,  16'd3,     16'hFFFB,   16'd7,      16'd29,     1'b0, "negx"};
    tv[2] = '{8'd127, 16'h4000,  16'd0,      16'd0,      16'h4000,   1'b0, "wrap"};
    tv[3] = '{8'd5,   16'd0,     16'd0,      16'hFFFF,   16'hFFFF,   1'b0, "const_m1"};
    tv[4] = '{8'h80,  16'd1,     16'd0,      16'd0,      16'h4000,   1'b0, "xmin_sq"};
    tv[5] = '{8'd10,  16'hFFFF,  16'd2,      16'd3,      16'hFFB3,   1'b0, "neg_a"};
    tv[6] = '{8'd0,   16'd5,     16'd6,      16'hFFFD,   16'hFFFD,   1'b0, "x_zero"};
    tv[7] = '{8'd1,   16'd2,     16'd3,      16'd4,      16'd9,      1'b1, "disturb"};

    rst = 1'b1; inicio = 1'b0; x = '0; a = '0; b = '0; c = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset state", {ready, valid, y}, {1'b1, 1'b0, 16'd0});

    for (int i = 0; i < 8; i++) run_eval(tv[i]);

    // inicio held high: valid every 6 cycles, ready one cycle between runs.
    x = 8'd1; a = 16'd2; b = 16'd3; c = 16'd4;
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    inicio = 1'b1;
    vseen = '0; rseen = '0; yok = 1'b1; nv = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      vseen[k-1] = valid;
      rseen[k-1] = ready;
      if (valid) begin
        nv++;
        if (y !== 16'd9) yok = 1'b0;
      end
    end
    inicio = 1'b0;
    vexp = '0; rexp = '0;
    vexp[4] = 1'b1; vexp[10] = 1'b1; vexp[16] = 1'b1;
    rexp[5] = 1'b1; rexp[11] = 1'b1; rexp[17] = 1'b1;
    chk("held inicio valid pattern", vseen, vexp);
    chk("held inicio ready pattern", rseen, rexp);
    chk("held inicio y each result", {nv[7:0], yok}, {8'd3, 1'b1});

    // Reset during MUL2 aborts the evaluation and clears y.
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    x = 8'd1; a = 16'd2; b = 16'd3; c = 16'd4;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset in MUL2 state", {ready, valid, y}, {1'b1, 1'b0, 16'd0});
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("no valid after abort", nv, 0);

    // rst wins over inicio in the same cycle.
    rst = 1'b1; inicio = 1'b1;
    @(negedge clk);
    rst = 1'b0; inicio = 1'b0;
    chk("rst priority over inicio", {ready, valid}, 2'b10);
    nv = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (valid || !ready) nv++;
    end
    chk("idle after rst+inicio", nv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
